// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage state encoding and reset/bubble constants.
package cpu_pkg;
  typedef enum logic {FETCH, DISCARD} state_t;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry {instr, pcplus} holding register for fetches completing under stall.
module if_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pcplus,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pcplus
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_instr  <= '0;
      o_pcplus <= '0;
    end else begin
      o_valid <= (i_clear || i_drain) ? 1'b0 : (i_load ? 1'b1 : o_valid);
      if (i_load) begin
        o_instr  <= i_instr;
        o_pcplus <= i_pcplus;
      end
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with req/ready memory handshake, redirect/discard handling and IF/ID register.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        PCSrcD,
  input  logic        jumpD,
  input  logic [31:0] pcchangeD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] irD,
  output logic [31:0] pcplusD,
  output logic        validD
);
  state_t      r_state, w_state_n;
  logic [31:0] r_pc, r_redir_pc, w_pc_n, w_redir_n, w_pc_plus;
  logic [31:0] w_ir_n, w_pcplus_n, w_buf_instr, w_buf_pcplus;
  logic        w_valid_n, w_load, w_drain, w_clear, w_buf_valid, w_accept, w_redirect;

  assign imem_addr  = r_pc;
  assign imem_req   = (r_state == FETCH && !w_buf_valid) || r_state == DISCARD;
  assign w_accept   = imem_req && imem_ready;
  assign w_redirect = validD && (PCSrcD || jumpD) && !stallD;
  assign w_pc_plus  = r_pc + 32'd4;

  if_skid_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_drain  (w_drain),
    .i_clear  (w_clear),
    .i_instr  (imem_rdata),
    .i_pcplus (w_pc_plus),
    .o_valid  (w_buf_valid),
    .o_instr  (w_buf_instr),
    .o_pcplus (w_buf_pcplus)
  );

  // Priority in FETCH: redirect, then flush (holds PC/buffer, drops any accepted word), then buffer, then memory.
  always_comb begin
    w_state_n  = r_state;
    w_pc_n     = r_pc;
    w_redir_n  = r_redir_pc;
    w_ir_n     = irD;
    w_pcplus_n = pcplusD;
    w_valid_n  = validD;
    w_load     = 1'b0;
    w_drain    = 1'b0;
    w_clear    = 1'b0;
    if (r_state == DISCARD) begin
      w_ir_n    = NOP_INSTR;
      w_valid_n = 1'b0;
      if (w_accept) begin
        w_pc_n    = r_redir_pc;
        w_state_n = FETCH;
      end
    end else if (w_redirect) begin
      w_clear   = 1'b1;
      w_ir_n    = NOP_INSTR;
      w_valid_n = 1'b0;
      if (w_accept || !imem_req) w_pc_n = pcchangeD;
      else begin
        w_redir_n = pcchangeD;
        w_state_n = DISCARD;
      end
    end else if (flushD) begin
      w_ir_n    = NOP_INSTR;
      w_valid_n = 1'b0;
    end else if (w_buf_valid) begin
      if (!stallD) begin
        w_ir_n     = w_buf_instr;
        w_pcplus_n = w_buf_pcplus;
        w_valid_n  = 1'b1;
        w_drain    = 1'b1;
      end
    end else if (w_accept) begin
      w_pc_n = w_pc_plus;
      w_load = stallD;
      if (!stallD) begin
        w_ir_n     = imem_rdata;
        w_pcplus_n = w_pc_plus;
        w_valid_n  = 1'b1;
      end
    end else if (!stallD) begin
      w_ir_n    = NOP_INSTR;
      w_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_redir_pc <= '0;
      irD        <= NOP_INSTR;
      pcplusD    <= '0;
      validD     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_redir_pc <= w_redir_n;
      irD        <= w_ir_n;
      pcplusD    <= w_pcplus_n;
      validD     <= w_valid_n;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios for if_stage against a word-indexed memory mem[a] = 0x2000_0000 + a/4.
module tb_if_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stallD = 1'b0, flushD = 1'b0, PCSrcD = 1'b0, jumpD = 1'b0;
  logic [31:0] pcchangeD = '0;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata, irD, pcplusD;
  logic        validD;
  logic        zw = 1'b1;
  int          wcnt = 0;
  int          n_pass = 0, n_total = 0;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stallD(stallD), .flushD(flushD), .PCSrcD(PCSrcD),
    .jumpD(jumpD), .pcchangeD(pcchangeD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .irD(irD), .pcplusD(pcplusD),
    .validD(validD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h2000_0000 + (a >> 2);
  endfunction

  assign imem_rdata = mem(imem_addr);
  assign imem_ready = zw || (imem_req && wcnt >= 2);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= 0;
    else wcnt <= (!imem_req || imem_ready) ? 0 : wcnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_total++; if ({irD, pcplusD, validD} !== {32'h0, 32'h0, 1'b0}) $display("FAIL reset_ifid ir=%h pc=%h v=%b want 0/0/0", irD, pcplusD, validD); else n_pass++;
    n_total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL reset_req req=%b addr=%h want 1/0", imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_zero_wait();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++;
      if ({irD, pcplusD, validD} !== {32'h2000_0000 + 32'(k), 32'(4 * (k + 1)), 1'b1})
        $display("FAIL zero_wait_%0d ir=%h pc=%h v=%b want %h/%h/1", k, irD, pcplusD, validD, 32'h2000_0000 + 32'(k), 4 * (k + 1));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    stallD = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++;
      if ({imem_req, irD, imem_addr} !== {1'b0, 32'h2000_0002, 32'h10})
        $display("FAIL stall_hold_%0d req=%b ir=%h addr=%h want 0/20000002/10", c, imem_req, irD, imem_addr);
      else n_pass++;
    end
    stallD = 1'b0;
    step();
    n_total++; if ({irD, pcplusD, validD} !== {32'h2000_0003, 32'h10, 1'b1}) $display("FAIL stall_drain ir=%h pc=%h v=%b want 20000003/10/1", irD, pcplusD, validD); else n_pass++;
    step();
    n_total++; if ({irD, pcplusD} !== {32'h2000_0004, 32'h14}) $display("FAIL stall_resume ir=%h pc=%h want 20000004/14", irD, pcplusD); else n_pass++;
  endtask

  task automatic test_jump();
    jumpD = 1'b1;
    pcchangeD = 32'h100;
    step();
    jumpD = 1'b0;
    n_total++; if ({validD, irD, imem_addr} !== {1'b0, 32'h0, 32'h100}) $display("FAIL jump_bubble v=%b ir=%h addr=%h want 0/0/100", validD, irD, imem_addr); else n_pass++;
    step();
    n_total++; if ({irD, pcplusD, validD} !== {32'h2000_0040, 32'h104, 1'b1}) $display("FAIL jump_target ir=%h pc=%h v=%b want 20000040/104/1", irD, pcplusD, validD); else n_pass++;
  endtask

  task automatic test_discard();
    zw = 1'b0;
    PCSrcD = 1'b1;
    pcchangeD = 32'h40;
    step();
    PCSrcD = 1'b0;
    n_total++; if ({validD, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h104}) $display("FAIL discard_enter v=%b req=%b addr=%h want 0/1/104", validD, imem_req, imem_addr); else n_pass++;
    step();
    n_total++; if ({validD, imem_addr} !== {1'b0, 32'h104}) $display("FAIL discard_hold v=%b addr=%h want 0/104", validD, imem_addr); else n_pass++;
    step();
    n_total++; if ({validD, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40}) $display("FAIL discard_exit v=%b req=%b addr=%h want 0/1/40", validD, imem_req, imem_addr); else n_pass++;
    step();
    step();
    n_total++; if (validD !== 1'b0) $display("FAIL discard_wait v=%b want 0", validD); else n_pass++;
    step();
    n_total++; if ({irD, pcplusD, validD} !== {32'h2000_0010, 32'h44, 1'b1}) $display("FAIL discard_target ir=%h pc=%h v=%b want 20000010/44/1", irD, pcplusD, validD); else n_pass++;
  endtask

  task automatic test_flush();
    zw = 1'b1;
    step();
    n_total++; if (irD !== 32'h2000_0011) $display("FAIL flush_pre ir=%h want 20000011", irD); else n_pass++;
    stallD = 1'b1;
    flushD = 1'b1;
    step();
    n_total++; if ({irD, validD, imem_addr} !== {32'h0, 1'b0, 32'h48}) $display("FAIL flush_stall ir=%h v=%b addr=%h want 0/0/48", irD, validD, imem_addr); else n_pass++;
    stallD = 1'b0;
    step();
    flushD = 1'b0;
    n_total++; if ({validD, imem_addr} !== {1'b0, 32'h48}) $display("FAIL flush_only v=%b addr=%h want 0/48", validD, imem_addr); else n_pass++;
    step();
    n_total++; if ({irD, pcplusD, validD} !== {32'h2000_0012, 32'h4C, 1'b1}) $display("FAIL flush_resume0 ir=%h pc=%h v=%b want 20000012/4c/1", irD, pcplusD, validD); else n_pass++;
    step();
    n_total++; if ({irD, pcplusD} !== {32'h2000_0013, 32'h50}) $display("FAIL flush_resume1 ir=%h pc=%h want 20000013/50", irD, pcplusD); else n_pass++;
  endtask

  task automatic test_reset_mid();
    zw = 1'b0;
    step();
    n_total++; if ({validD, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h50}) $display("FAIL rmid_wait v=%b req=%b addr=%h want 0/1/50", validD, imem_req, imem_addr); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({irD, pcplusD, validD, imem_req, imem_addr} !== {32'h0, 32'h0, 1'b0, 1'b1, 32'h0})
      $display("FAIL rmid_async ir=%h pc=%h v=%b req=%b addr=%h want 0/0/0/1/0", irD, pcplusD, validD, imem_req, imem_addr);
    else n_pass++;
    step();
    rst_n = 1'b1;
    zw = 1'b1;
    step();
    n_total++; if ({irD, pcplusD, validD} !== {32'h2000_0000, 32'h4, 1'b1}) $display("FAIL rmid_restart ir=%h pc=%h v=%b want 20000000/4/1", irD, pcplusD, validD); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_jump();
    test_discard();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. It owns the fetch PC and issues requests to instruction memory over a req/ready handshake. It delivers irD/pcplusD/validD to decode, and applies redirects (PCSrcD/jumpD with pcchangeD) and stalls/flushes from the hazard unit. A 1-entry skid buffer absorbs a fetch that completes while decode is stalled.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on a bubble

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
stallD  in  1  hazard unit: hold IF/ID contents
flushD  in  1  hazard unit: load bubble into IF/ID
PCSrcD  in  1  decode: conditional branch taken
jumpD  in  1  decode: j/jr
pcchangeD  in  32  decode: redirect target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (word aligned)
imem_ready  in  1  request accepted; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
irD  out  32  IF/ID instruction
pcplusD  out  32  IF/ID fetch address + 4
validD  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0): pcF=RESET_PC, state=FETCH, buf_valid=0, irD=NOP_INSTR, pcplusD=0, validD=0, redir_pc=0.
- imem_addr=pcF always. imem_req = (state==FETCH && !buf_valid) || state==DISCARD.
- Protocol: once imem_req is high, it and imem_addr stay stable until an edge samples imem_ready=1 ("accept"). imem_ready may be high in the same cycle as the request (zero-wait), giving 1 instr/cycle.
- redirect = validD && (PCSrcD || jumpD) && !stallD. There is no delay slot. The instruction behind a redirecting one is squashed.
- States: FETCH, DISCARD.
- FETCH, accept, no redirect, !stallD: irD<=imem_rdata, pcplusD<=pcF+4, validD<=1, pcF<=pcF+4.
- FETCH, accept, no redirect, stallD: buf<={imem_rdata,pcF+4}, buf_valid<=1, pcF<=pcF+4. IF/ID holds.
- buf_valid, !stallD, no redirect: IF/ID<=buf, validD<=1, buf_valid<=0. Fetch resumes the next cycle.
- FETCH, no accept, no buf, !stallD, no redirect: validD<=0, irD<=NOP_INSTR (bubble).
- redirect, with accept or no request outstanding: pcF<=pcchangeD, buf_valid<=0, IF/ID<=bubble, stay FETCH. Accepted data is dropped.
- redirect with request outstanding and not accepted: redir_pc<=pcchangeD, buf_valid<=0, IF/ID<=bubble, go DISCARD. The old request is kept stable.
- DISCARD: on accept, drop the data, pcF<=redir_pc, go FETCH. IF/ID stays a bubble. A redirect cannot occur in DISCARD because validD=0.
- flushD: IF/ID<=bubble regardless of stallD (flush beats stall). PC and buffer are unaffected unless redirect also fires.
- stallD alone: IF/ID unchanged, and pcF advances only via the buffer rule.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. pcchangeD is used as-is (low bits not checked).
- Reset mid-transaction: everything returns to reset values immediately. The memory side must tolerate the request being dropped.

Decomposition:
- Shared package (cpu_pkg): state encoding (FETCH, DISCARD), RESET_PC default, NOP_INSTR constant.
- One sub-module, if_skid_buf: 1-entry {instr, pcplus} register with valid/load/drain/clear.
- PC/state logic and the IF/ID register stay in if_stage.

Test Plan:
- Zero-wait memory (ready tied 1), instr[k]=0x2000_0000+k, no stalls -> after reset irD follows k=0,1,2 on consecutive cycles, pcplusD=4,8,12, validD=1 from the first edge after reset release.
- stallD=1 for 3 cycles while a fetch is accepted -> buf_valid=1, imem_req=0, irD held. On stallD=0, the next irD is the buffered word with the correct pcplusD and none is lost or duplicated.
- jumpD=1 with pcchangeD=0x0000_0100 while the next fetch is accepted the same cycle -> following IF/ID is a bubble (validD=0), then imem_addr=0x100 and irD=mem[0x100].
- Memory with 3-cycle ready latency; PCSrcD=1, pcchangeD=0x40 while a request is outstanding -> DISCARD, old address held until ready, its data dropped, then imem_addr=0x40.
- flushD and stallD asserted together -> irD=NOP_INSTR, validD=0, pcF unchanged. Then flushD alone for 1 cycle -> one bubble and fetch continues in order.
- rst_n deasserted mid-wait (ready pending) -> outputs immediately at reset values. After release, imem_addr=RESET_PC and imem_req=1.
